// File: rtl/ss_pkg.sv
// Shared types and helpers for the space-saving update engine.
package ss_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SEARCH,
        INC,
        WB,
        ALLOC,
        SCAN,
        EVICT,
        MAX,
        MAXCAP
    } state_t;

    // cnt_cam needs max_en held through all of its comparison phases.
    localparam int MAX_PHASES = 4;

    // value+1, clamped at the all-ones code of a width-bit counter.
    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] all_ones;
        all_ones = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (value >= all_ones) ? all_ones : value + 32'd1;
    endfunction

endpackage

// File: rtl/ss_update_ctrl_if.sv
// Bus between the update engine and its key CAM / count CAM pair.
interface ss_update_ctrl_if #(
    parameter int KEY_SIZE    = 16,
    parameter int WORD_SIZE   = 13,
    parameter int ENTRY_WIDTH = 7
);
    logic [KEY_SIZE-1:0]    key_data;
    logic [ENTRY_WIDTH-1:0] key_addr;
    logic                   key_search_en;
    logic                   key_write_en;
    logic                   key_reset;
    logic                   key_match;
    logic [ENTRY_WIDTH-1:0] key_match_addr;

    logic [WORD_SIZE-1:0]   cnt_wdata;
    logic [ENTRY_WIDTH-1:0] cnt_addr;
    logic                   cnt_read_en;
    logic                   cnt_write_en;
    logic                   cnt_reset;
    logic [WORD_SIZE-1:0]   cnt_rdata;
    logic                   max_en;
    logic [WORD_SIZE-1:0]   cnt_max;

    modport master (
        output key_data, key_addr, key_search_en, key_write_en, key_reset,
        output cnt_wdata, cnt_addr, cnt_read_en, cnt_write_en, cnt_reset, max_en,
        input  key_match, key_match_addr, cnt_rdata, cnt_max
    );

    modport slave (
        input  key_data, key_addr, key_search_en, key_write_en, key_reset,
        input  cnt_wdata, cnt_addr, cnt_read_en, cnt_write_en, cnt_reset, max_en,
        output key_match, key_match_addr, cnt_rdata, cnt_max
    );
endinterface

// File: rtl/ss_min_scan.sv
// Walks every count row once and tracks the lowest count; ties keep the lowest index.
module ss_min_scan #(
    parameter int WORD_SIZE   = 13,
    parameter int ENTRY_WIDTH = 7,
    parameter int ROW_NUM     = 128
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   en,
    input  logic [WORD_SIZE-1:0]   rdata,
    output logic [ENTRY_WIDTH-1:0] idx,
    output logic                   done,
    output logic [WORD_SIZE-1:0]   min_val,
    output logic [ENTRY_WIDTH-1:0] min_idx
);
    localparam logic [ENTRY_WIDTH-1:0] LAST_IDX = ENTRY_WIDTH'(ROW_NUM - 1);

    assign done = en & (idx == LAST_IDX);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            idx     <= '0;
            min_val <= '0;
            min_idx <= '0;
        end else if (start) begin
            idx <= '0;
        end else if (en) begin
            idx <= done ? '0 : idx + 1'b1;
            // Row 0 seeds the tracker; strict less-than keeps the first of equal minima.
            if (idx == '0 || rdata < min_val) begin
                min_val <= rdata;
                min_idx <= idx;
            end
        end
    end
endmodule

// File: rtl/ss_update_ctrl.sv
// Space-saving update engine: drives the key CAM and count CAM for hit, allocate,
// evict-minimum and read-maximum transactions.
module ss_update_ctrl
    import ss_pkg::*;
#(
    parameter int KEY_SIZE    = 16,
    parameter int WORD_SIZE   = 13,
    parameter int ENTRY_WIDTH = 7,
    parameter int ROW_NUM     = 128
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clear,
    input  logic                 item_valid,
    input  logic [KEY_SIZE-1:0]  item_key,
    output logic                 item_ready,
    input  logic                 max_req,
    output logic                 max_valid,
    output logic [WORD_SIZE-1:0] max_value,
    output logic                 busy,
    ss_update_ctrl_if.master     cam
);
    localparam logic [ENTRY_WIDTH:0] FULL     = (ENTRY_WIDTH + 1)'(ROW_NUM);
    localparam logic [1:0]           LAST_PH  = 2'(MAX_PHASES - 1);

    state_t                 state, state_nxt;
    logic [KEY_SIZE-1:0]    key_q;
    logic [ENTRY_WIDTH-1:0] addr_q;
    logic [WORD_SIZE-1:0]   cnt_q;
    logic [ENTRY_WIDTH:0]   fill_cnt;
    logic [1:0]             max_ph;
    logic                   max_hold;
    logic                   hit, max_go, accept;
    logic                   scan_start, scan_done;
    logic [ENTRY_WIDTH-1:0] scan_idx, min_idx;
    logic [WORD_SIZE-1:0]   min_val, cnt_inc, min_inc;

    // A match on a row past the fill point is a stale entry, not a hit.
    assign hit        = cam.key_match & ({1'b0, cam.key_match_addr} < fill_cnt);
    assign max_go     = max_req & ~max_hold;
    assign item_ready = rstn & (state == IDLE) & ~clear & ~max_req;
    assign accept     = item_valid & item_ready;
    assign busy       = (state != IDLE);
    assign cnt_inc    = WORD_SIZE'(sat_inc(32'(cnt_q), WORD_SIZE));
    assign min_inc    = WORD_SIZE'(sat_inc(32'(min_val), WORD_SIZE));

    ss_min_scan #(
        .WORD_SIZE  (WORD_SIZE),
        .ENTRY_WIDTH(ENTRY_WIDTH),
        .ROW_NUM    (ROW_NUM)
    ) u_min_scan (
        .clk    (clk),
        .rstn   (rstn),
        .start  (scan_start),
        .en     (state == SCAN),
        .rdata  (cam.cnt_rdata),
        .idx    (scan_idx),
        .done   (scan_done),
        .min_val(min_val),
        .min_idx(min_idx)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            key_q     <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            fill_cnt  <= '0;
            max_ph    <= '0;
            max_hold  <= 1'b0;
            max_value <= '0;
            max_valid <= 1'b0;
        end else begin
            state     <= state_nxt;
            max_valid <= (state == MAXCAP);
            max_ph    <= (state == MAX) ? max_ph + 2'd1 : 2'd0;

            // A served request stays consumed until max_req drops.
            if (!max_req)
                max_hold <= 1'b0;
            else if (state == IDLE && !clear && max_go)
                max_hold <= 1'b1;

            if (accept)
                key_q <= item_key;
            if (state == SEARCH)
                addr_q <= cam.key_match_addr;
            if (state == INC)
                cnt_q <= cam.cnt_rdata;
            if (state == MAXCAP)
                max_value <= cam.cnt_max;

            if (state == IDLE && clear)
                fill_cnt <= '0;
            else if (state == ALLOC && fill_cnt < FULL)
                fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt         = state;
        scan_start        = 1'b0;
        cam.key_data      = '0;
        cam.key_addr      = '0;
        cam.key_search_en = 1'b0;
        cam.key_write_en  = 1'b0;
        cam.key_reset     = 1'b0;
        cam.cnt_wdata     = '0;
        cam.cnt_addr      = '0;
        cam.cnt_read_en   = 1'b0;
        cam.cnt_write_en  = 1'b0;
        cam.cnt_reset     = 1'b0;
        cam.max_en        = 1'b0;

        unique case (state)
            IDLE: begin
                if (clear) begin
                    cam.key_reset = rstn;
                    cam.cnt_reset = rstn;
                end else if (max_go) begin
                    state_nxt = MAX;
                end else if (accept) begin
                    state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                cam.key_search_en = 1'b1;
                cam.key_data      = key_q;
                if (hit) begin
                    state_nxt = INC;
                end else if (fill_cnt < FULL) begin
                    state_nxt = ALLOC;
                end else begin
                    state_nxt  = SCAN;
                    scan_start = 1'b1;
                end
            end
            INC: begin
                cam.cnt_read_en = 1'b1;
                cam.cnt_addr    = addr_q;
                state_nxt       = WB;
            end
            WB: begin
                cam.cnt_write_en = 1'b1;
                cam.cnt_addr     = addr_q;
                cam.cnt_wdata    = cnt_inc;
                state_nxt        = IDLE;
            end
            ALLOC: begin
                cam.key_write_en = 1'b1;
                cam.key_addr     = fill_cnt[ENTRY_WIDTH-1:0];
                cam.key_data     = key_q;
                cam.cnt_write_en = 1'b1;
                cam.cnt_addr     = fill_cnt[ENTRY_WIDTH-1:0];
                cam.cnt_wdata    = WORD_SIZE'(1);
                state_nxt        = IDLE;
            end
            SCAN: begin
                cam.cnt_read_en = 1'b1;
                cam.cnt_addr    = scan_idx;
                if (scan_done)
                    state_nxt = EVICT;
            end
            EVICT: begin
                cam.key_write_en = 1'b1;
                cam.key_addr     = min_idx;
                cam.key_data     = key_q;
                cam.cnt_write_en = 1'b1;
                cam.cnt_addr     = min_idx;
                cam.cnt_wdata    = min_inc;
                state_nxt        = IDLE;
            end
            MAX: begin
                cam.max_en = 1'b1;
                if (max_ph == LAST_PH)
                    state_nxt = MAXCAP;
            end
            MAXCAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end
endmodule

// File: tb/tb_ss_update_ctrl.sv
// Self-checking bench: behavioural key/count CAMs plus a key->count table reference model.
module tb_ss_update_ctrl;
    localparam int KS   = 16;
    localparam int WS   = 4;
    localparam int EW   = 2;
    localparam int ROWS = 4;
    localparam int WMAX = 15;

    logic          clk = 1'b0;
    logic          rstn;
    logic          clear;
    logic          item_valid;
    logic [KS-1:0] item_key;
    logic          item_ready;
    logic          max_req;
    logic          max_valid;
    logic [WS-1:0] max_value;
    logic          busy;

    int tests = 0;
    int fails = 0;

    ss_update_ctrl_if #(.KEY_SIZE(KS), .WORD_SIZE(WS), .ENTRY_WIDTH(EW)) cam_bus ();

    ss_update_ctrl #(.KEY_SIZE(KS), .WORD_SIZE(WS), .ENTRY_WIDTH(EW), .ROW_NUM(ROWS)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (clear),
        .item_valid(item_valid),
        .item_key  (item_key),
        .item_ready(item_ready),
        .max_req   (max_req),
        .max_valid (max_valid),
        .max_value (max_value),
        .busy      (busy),
        .cam       (cam_bus)
    );

    always #5 clk = ~clk;

    // Behavioural CAMs: contents survive rstn, wiped only by their reset strobes.
    logic [KS-1:0] key_mem [ROWS];
    logic [WS-1:0] cnt_mem [ROWS];
    logic          m_match;
    logic [EW-1:0] m_addr;
    logic [WS-1:0] m_max;

    always_comb begin
        m_match = 1'b0;
        m_addr  = '0;
        if (cam_bus.key_search_en)
            for (int i = ROWS - 1; i >= 0; i--)
                if (key_mem[i] == cam_bus.key_data) begin
                    m_match = 1'b1;
                    m_addr  = EW'(i);
                end
        m_max = '0;
        for (int i = 0; i < ROWS; i++)
            if (cnt_mem[i] > m_max) m_max = cnt_mem[i];
    end

    assign cam_bus.key_match      = m_match;
    assign cam_bus.key_match_addr = m_addr;
    assign cam_bus.cnt_rdata      = cam_bus.cnt_read_en ? cnt_mem[cam_bus.cnt_addr] : '0;
    assign cam_bus.cnt_max        = m_max;

    always @(posedge clk) begin
        if (cam_bus.key_reset)
            for (int i = 0; i < ROWS; i++) key_mem[i] <= '0;
        else if (cam_bus.key_write_en)
            key_mem[cam_bus.key_addr] <= cam_bus.key_data;
        if (cam_bus.cnt_reset)
            for (int i = 0; i < ROWS; i++) cnt_mem[i] <= '0;
        else if (cam_bus.cnt_write_en)
            cnt_mem[cam_bus.cnt_addr] <= cam_bus.cnt_wdata;
    end

    // Reference: space-saving table as plain arrays.
    logic [KS-1:0] r_key [ROWS];
    int            r_cnt [ROWS];
    int            r_fill;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [6:0] strobes();
        return {cam_bus.key_search_en, cam_bus.key_write_en, cam_bus.key_reset,
                cam_bus.cnt_read_en, cam_bus.cnt_write_en, cam_bus.cnt_reset, cam_bus.max_en};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_clear();
        r_fill = 0;
        for (int i = 0; i < ROWS; i++) begin
            r_key[i] = '0;
            r_cnt[i] = 0;
        end
    endtask

    task automatic ref_item(input logic [KS-1:0] k, output int lat);
        int row;
        row = -1;
        for (int i = 0; i < r_fill; i++)
            if (r_key[i] == k) row = i;
        if (row >= 0) begin
            r_cnt[row] = (r_cnt[row] < WMAX) ? r_cnt[row] + 1 : WMAX;
            lat = 4;
        end else if (r_fill < ROWS) begin
            r_key[r_fill] = k;
            r_cnt[r_fill] = 1;
            r_fill++;
            lat = 3;
        end else begin
            row = 0;
            for (int i = 1; i < ROWS; i++)
                if (r_cnt[i] < r_cnt[row]) row = i;
            r_key[row] = k;
            r_cnt[row] = (r_cnt[row] < WMAX) ? r_cnt[row] + 1 : WMAX;
            lat = ROWS + 3;
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        #1;
        check("clear_key_reset", cam_bus.key_reset, 1);
        check("clear_ready", item_ready, 0);
        tick();
        clear = 1'b0;
        ref_clear();
    endtask

    task automatic do_item(input logic [KS-1:0] k);
        int exp_lat, lat;
        ref_item(k, exp_lat);
        item_valid = 1'b1;
        item_key   = k;
        tick();
        item_valid = 1'b0;
        item_key   = '0;
        lat = 1;
        while (!item_ready && lat < 300) begin
            tick();
            lat++;
        end
        check($sformatf("lat_%0h", k), lat, exp_lat);
        for (int i = 0; i < r_fill; i++) begin
            check($sformatf("key[%0d]", i), key_mem[i], r_key[i]);
            check($sformatf("cnt[%0d]", i), cnt_mem[i], r_cnt[i]);
        end
    endtask

    task automatic do_max(input logic [WS-1:0] exp_val);
        int en_cyc, pulses, vpos;
        en_cyc = 0;
        pulses = 0;
        vpos   = 0;
        max_req = 1'b1;
        for (int n = 1; n <= 14; n++) begin
            tick();
            if (cam_bus.max_en) en_cyc++;
            if (max_valid) begin
                pulses++;
                if (vpos == 0) vpos = n;
            end
        end
        check("max_en_cycles", en_cyc, 4);
        check("max_valid_pos", vpos, 6);
        check("max_pulses", pulses, 1);
        check("max_value", max_value, exp_val);
        max_req = 1'b0;
        tick();
    endtask

    initial begin
        logic [KS-1:0] pool [6];
        int k;
        pool = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055, 16'h0066};
        rstn = 1'b0; clear = 1'b1; item_valid = 1'b0; item_key = '0; max_req = 1'b0;
        ref_clear();

        // Reset: outputs quiet even with clear held.
        #1;
        check("rst_strobes", strobes(), 0);
        check("rst_ready", item_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_max_valid", max_valid, 0);
        check("rst_max_value", max_value, 0);
        clear = 1'b0;
        repeat (2) @(posedge clk);
        #3 rstn = 1'b1;
        tick();
        check("post_rst_ready", item_ready, 1);
        check("post_rst_data", {cam_bus.key_data, cam_bus.cnt_wdata, cam_bus.key_addr, cam_bus.cnt_addr}, 0);

        // Allocate two rows, then hit the first.
        do_clear();
        do_item(16'h0011);
        do_item(16'h0022);
        do_item(16'h0011);
        check("hit_cnt0", cnt_mem[0], 2);
        check("hit_cnt1", cnt_mem[1], 1);

        // Stale match on a cleared row must allocate, not hit.
        do_clear();
        do_item(16'h0000);
        check("stale_cnt0", cnt_mem[0], 1);

        // Counts 3,1,1,2 then a new key evicts row 1 (lowest-index tie).
        do_clear();
        repeat (3) do_item(16'h00a1);
        do_item(16'h00b2);
        do_item(16'h00c3);
        repeat (2) do_item(16'h00d4);
        do_item(16'h0099);
        check("evict_key1", key_mem[1], 16'h0099);
        check("evict_cnt1", cnt_mem[1], 2);

        // Saturation at all-ones.
        repeat (15) do_item(16'h0099);
        check("sat_cnt1", cnt_mem[1], WMAX);

        // Randomized traffic against the reference table.
        do_clear();
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(9) == 0) do_clear();
            k = $urandom_range(5);
            do_item(pool[k]);
        end

        // Max readout: counts 3,7,2,5.
        do_clear();
        repeat (3) do_item(16'h0101);
        repeat (7) do_item(16'h0202);
        repeat (2) do_item(16'h0303);
        repeat (5) do_item(16'h0404);
        do_max(4'd7);

        // clear and max_req together: clear wins, held request served afterwards.
        clear   = 1'b1;
        max_req = 1'b1;
        #1;
        check("clr_max_key_reset", cam_bus.key_reset, 1);
        check("clr_max_no_max_en", cam_bus.max_en, 0);
        tick();
        clear = 1'b0;
        ref_clear();
        check("clr_max_idle", busy, 0);
        do_max(4'd0);

        // Asynchronous reset in the middle of a scan.
        do_clear();
        do_item(16'h0a0a);
        do_item(16'h0b0b);
        do_item(16'h0c0c);
        do_item(16'h0d0d);
        item_valid = 1'b1;
        item_key   = 16'h0e0e;
        tick();
        item_valid = 1'b0;
        tick();
        tick();
        check("scan_read_en", cam_bus.cnt_read_en, 1);
        #2 rstn = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_strobes", strobes(), 0);
        check("abort_ready", item_ready, 0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        check("abort_recover_ready", item_ready, 1);

        // Scan after the abort must still pick the true minimum.
        do_clear();
        do_item(16'h0a0a);
        do_item(16'h0b0b);
        do_item(16'h0b0b);
        do_item(16'h0c0c);
        do_item(16'h0d0d);
        do_item(16'h0e0e);
        check("post_abort_evict", key_mem[0], 16'h0e0e);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
